uart_rx: RTL and testbench

- UART receiver for the serial path: 8N1 frames, LSB first, idle-high line.
- Generates its own oversampling tick from `clk`, using the same divisor arithmetic as the baud generator.
- Samples at mid-bit and delivers each byte as a single-cycle valid pulse to the downstream consumer.
- Single clock domain. The only asynchronous input is `rx`.

---
 rtl/uart_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, internal oversampling
// tick divider and mid-bit sampling; bytes are delivered as one-cycle pulses.
module uart_rx #(
    parameter int boud_rate = 9600,
    parameter int clk_freq  = 1000000,
    parameter int sampling  = 16,
    parameter int n         = 9,
    parameter int divisor   = clk_freq / (boud_rate * sampling)
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int sw = $clog2(sampling);

    localparam logic [n-1:0]  tick_last = n'(divisor - 1);
    localparam logic [n-1:0]  tick_one  = n'(1);
    localparam logic [sw-1:0] scnt_mid  = sw'(sampling / 2 - 1);
    localparam logic [sw-1:0] scnt_last = sw'(sampling - 1);
    localparam logic [sw-1:0] scnt_one  = sw'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state_reg,     state_next;
    logic [n-1:0]  tick_cnt_reg,  tick_cnt_next;
    logic [sw-1:0] scnt_reg,      scnt_next;
    logic [2:0]    bit_idx_reg,   bit_idx_next;
    logic [7:0]    shreg_reg,     shreg_next;
    logic [7:0]    rx_data_reg,   rx_data_next;
    logic          rx_valid_reg,  rx_valid_next;
    logic          frame_err_reg, frame_err_next;
    logic          sync1_reg,     sync2_reg;
    logic          rx_s;
    logic          tick;

    // Synchronizer resets to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= rx;
            sync2_reg <= sync1_reg;
        end
    end

    assign rx_s = sync2_reg;
    assign tick = (state_reg != IDLE) && (tick_cnt_reg == tick_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            tick_cnt_reg  <= '0;
            scnt_reg      <= '0;
            bit_idx_reg   <= '0;
            shreg_reg     <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tick_cnt_reg  <= tick_cnt_next;
            scnt_reg      <= scnt_next;
            bit_idx_reg   <= bit_idx_next;
            shreg_reg     <= shreg_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Divider phase is pinned to 0 while idle so the first tick lands a fixed
    // distance after the synchronized start edge.
    always_comb begin
        tick_cnt_next = tick_cnt_reg;
        if (state_reg == IDLE) begin
            tick_cnt_next = '0;
        end else if (tick) begin
            tick_cnt_next = '0;
        end else begin
            tick_cnt_next = tick_cnt_reg + tick_one;
        end
    end

    always_comb begin
        state_next     = state_reg;
        scnt_next      = scnt_reg;
        bit_idx_next   = bit_idx_reg;
        shreg_next     = shreg_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                scnt_next    = '0;
                bit_idx_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end

            START: begin
                if (tick) begin
                    if (scnt_reg == scnt_mid) begin
                        scnt_next    = '0;
                        bit_idx_next = '0;
                        state_next   = rx_s ? IDLE : DATA;
                    end else begin
                        scnt_next = scnt_reg + scnt_one;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (scnt_reg == scnt_last) begin
                        shreg_next   = {rx_s, shreg_reg[7:1]};
                        scnt_next    = '0;
                        bit_idx_next = bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_next = STOP;
                        end
                    end else begin
                        scnt_next = scnt_reg + scnt_one;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (scnt_reg == scnt_last) begin
                        rx_data_next = shreg_reg;
                        scnt_next    = '0;
                        if (rx_s) begin
                            rx_valid_next = 1'b1;
                            state_next    = IDLE;
                        end else begin
                            frame_err_next = 1'b1;
                            state_next     = BREAK;
                        end
                    end else begin
                        scnt_next = scnt_reg + scnt_one;
                    end
                end
            end

            // A line held low after a bad stop bit must go high before re-arming.
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 160 clk per bit (divisor 10, 16x oversampling).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    localparam int BIT = 160;
    // rx driven before posedge k: 2 sync flops + 80 clk to mid-start + 9*160 to mid-stop + 1 register.
    localparam int PULSE_LAT = 1523;
    localparam int BUSY_LAT  = 3;
    localparam int GLITCH_FALL = 83;

    uart_rx #(
        .boud_rate(10000),
        .clk_freq (1600000),
        .sampling (16),
        .n        (9)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    logic [7:0] vdata [0:31];
    int         vtime [0:31];
    int         vcnt = 0;
    int         fcnt = 0;
    logic [7:0] fdata = 8'h00;
    int         overlap = 0;
    int         longp = 0;
    int         busy_rise = 0;
    int         busy_fall = 0;
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (vcnt < 32) begin
                vdata[vcnt] <= rx_data;
                vtime[vcnt] <= cyc;
            end
            vcnt <= vcnt + 1;
        end
        if (frame_err === 1'b1) begin
            fdata <= rx_data;
            fcnt  <= fcnt + 1;
        end
        if (rx_valid === 1'b1 && frame_err === 1'b1) overlap <= overlap + 1;
        if ((rx_valid === 1'b1 && prev_v) || (frame_err === 1'b1 && prev_f)) longp <= longp + 1;
        if (busy === 1'b1 && !prev_busy) busy_rise <= cyc;
        if (busy !== 1'b1 && prev_busy) busy_fall <= cyc;
        prev_v    <= (rx_valid === 1'b1);
        prev_f    <= (frame_err === 1'b1);
        prev_busy <= (busy === 1'b1);
    end

    int t_start = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clks(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    // Drives a full 10-bit frame; ends exactly one frame after the start edge
    // with rx left at the stop level so calls can be chained back to back.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        t_start = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    int v0, f0, t0, t1, t2, tg;

    initial begin
        // Reset
        rstn = 1'b0;
        rx   = 1'b1;
        wait_clks(5);
        chk("reset rx_data",   {24'd0, rx_data}, 32'h00);
        chk("reset rx_valid",  {31'd0, rx_valid}, 32'd0);
        chk("reset frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset busy",      {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        wait_clks(2000);
        chk("idle no valid", vcnt, 0);
        chk("idle no ferr",  fcnt, 0);
        chk("idle busy",     {31'd0, busy}, 32'd0);

        // Single frame 0xA5
        v0 = vcnt; f0 = fcnt;
        send_frame(8'hA5, 1'b1);
        t0 = t_start;
        wait_clks(10);
        chk("single count",    vcnt - v0, 1);
        chk("single data",     {24'd0, vdata[v0]}, 32'hA5);
        chk("single latency",  vtime[v0] - t0, PULSE_LAT);
        chk("single rx_data",  {24'd0, rx_data}, 32'hA5);
        chk("single no ferr",  fcnt - f0, 0);
        chk("single busy rise", busy_rise - t0, BUSY_LAT);
        chk("single busy fall", busy_fall - t0, PULSE_LAT);

        // Back-to-back 0x00, 0xFF, 0x3C
        v0 = vcnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_clks(10);
        chk("b2b count",  vcnt - v0, 3);
        chk("b2b data0",  {24'd0, vdata[v0]},     32'h00);
        chk("b2b data1",  {24'd0, vdata[v0 + 1]}, 32'hFF);
        chk("b2b data2",  {24'd0, vdata[v0 + 2]}, 32'h3C);
        t1 = vtime[v0 + 1] - vtime[v0];
        t2 = vtime[v0 + 2] - vtime[v0 + 1];
        chk("b2b spacing01", {31'd0, (t1 >= 1598 && t1 <= 1602)}, 32'd1);
        chk("b2b spacing12", {31'd0, (t2 >= 1598 && t2 <= 1602)}, 32'd1);

        // Glitch: 40 clk low pulse is rejected at mid-start
        v0 = vcnt; f0 = fcnt;
        rx = 1'b0;
        tg = cyc;
        wait_clks(40);
        rx = 1'b1;
        wait_clks(200);
        chk("glitch busy fall", busy_fall - tg, GLITCH_FALL);
        chk("glitch no valid",  vcnt - v0, 0);
        chk("glitch no ferr",   fcnt - f0, 0);
        chk("glitch busy",      {31'd0, busy}, 32'd0);
        send_frame(8'h5A, 1'b1);
        wait_clks(10);
        chk("post-glitch count", vcnt - v0, 1);
        chk("post-glitch data",  {24'd0, vdata[v0]}, 32'h5A);

        // Framing error then held-low break
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h81, 1'b0);
        wait_clks(3000);
        chk("ferr count",     fcnt - f0, 1);
        chk("ferr data",      {24'd0, fdata}, 32'h81);
        chk("ferr rx_data",   {24'd0, rx_data}, 32'h81);
        chk("ferr no valid",  vcnt - v0, 0);
        chk("break busy",     {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_clks(200);
        chk("break release busy", {31'd0, busy}, 32'd0);
        send_frame(8'h42, 1'b1);
        wait_clks(10);
        chk("post-break count", vcnt - v0, 1);
        chk("post-break data",  {24'd0, vdata[v0]}, 32'h42);
        chk("post-break ferr",  fcnt - f0, 1);

        // Reset during bit 4 of 0xC3
        v0 = vcnt; f0 = fcnt;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i < 2) ? 1'b1 : 1'b0;
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b0;
        wait_clks(80);
        chk("midframe busy", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("midreset rx_data",   {24'd0, rx_data}, 32'h00);
        chk("midreset busy",      {31'd0, busy}, 32'd0);
        chk("midreset rx_valid",  {31'd0, rx_valid}, 32'd0);
        chk("midreset frame_err", {31'd0, frame_err}, 32'd0);
        rx = 1'b1;
        wait_clks(5);
        rstn = 1'b1;
        wait_clks(2000);
        chk("midreset no valid", vcnt - v0, 0);
        chk("midreset no ferr",  fcnt - f0, 0);
        send_frame(8'h18, 1'b1);
        wait_clks(10);
        chk("post-reset count", vcnt - v0, 1);
        chk("post-reset data",  {24'd0, vdata[v0]}, 32'h18);

        chk("pulse overlap", overlap, 0);
        chk("pulse width",   longp, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
